pe_tile_scheduler: RTL and testbench

Sequencer that drives one Winograd PE chain: walks every output tile position of an input feature map and every output channel, and issues matched data-tile and weight-tile requests to the input and weight transform units on the same cycle. It counts returning PE results and tracks outstanding work, so the top-level controller gets a single done pulse only after the PE pipeline has drained.

---
 rtl/pe_tile_scheduler.sv | 179 +++++++++++++++++
 tb/tb_pe_tile_scheduler.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pe_tile_scheduler.sv
// Purpose: walks every output tile (x, y) and output channel of a feature map and issues paired
//          data/weight tile requests to the input and weight transform units on the same cycle.
//          It also counts returning PE results and pulses done only after the PE pipeline drains.
// Latency: the first request is valid the cycle after start, then one issue per cycle.
//          done follows one cycle after the drain phase observes zero outstanding results.
// Backpressure: a request is held with stable fields until both transform units are ready.
//          req_valid is masked while the outstanding-result counter sits at its maximum.
// Ports:   clk/reset (sync, active low); start + cfg_* latch a job in IDLE; itrans_ready/wtrans_ready
//          with req_valid form the issue handshake; data_x_index/data_y_index/weight_od/weight_size_type
//          carry the request; pe_result_valid returns results; busy/done/err_overflow report status.
// Option:  define SCHED_PERF_EN to add perf_stall_cycles (RUN cycles with req_valid high but no fire).
module pe_tile_scheduler #(
  parameter int OUTSTANDING_W = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [8:0] cfg_img_h,
  input  logic [8:0] cfg_img_w,
  input  logic [7:0] cfg_num_od,
  input  logic       cfg_size_type,
  input  logic       itrans_ready,
  input  logic       wtrans_ready,
  output logic       req_valid,
  output logic [8:0] data_x_index,
  output logic [8:0] data_y_index,
  output logic [7:0] weight_od,
  output logic       weight_size_type,
  input  logic       pe_result_valid,
  output logic       busy,
  output logic       done,
  output logic       err_overflow
`ifdef SCHED_PERF_EN
  ,
  output logic [31:0] perf_stall_cycles
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [OUTSTANDING_W-1:0] OUT_MAX  = '1;
  localparam logic [OUTSTANDING_W-1:0] OUT_ZERO = '0;
  localparam logic [OUTSTANDING_W-1:0] OUT_ONE  = OUTSTANDING_W'(1);

  state_t                   state_q, state_d;
  logic [8:0]               x_q, x_d, y_q, y_d;
  logic [7:0]               od_q, od_d;
  logic [8:0]               img_h_q, img_h_d, img_w_q, img_w_d;
  logic [7:0]               num_od_q, num_od_d;
  logic                     size_q, size_d;
  logic [OUTSTANDING_W-1:0] outst_q, outst_d;
  logic                     err_q, err_d;
`ifdef SCHED_PERF_EN
  logic [31:0]              perf_q, perf_d;
`endif

  logic [8:0] step;
  logic [9:0] x_next, y_next;  // extra carry bit so origin+step never wraps before the compare
  logic       x_last, y_last, od_last, fire, result_ok;

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    od_d     = od_q;
    img_h_d  = img_h_q;
    img_w_d  = img_w_q;
    num_od_d = num_od_q;
    size_d   = size_q;
    outst_d  = outst_q;
    err_d    = err_q;
`ifdef SCHED_PERF_EN
    perf_d   = perf_q;
`endif

    step      = size_q ? 9'd4 : 9'd6;
    x_next    = {1'b0, x_q} + {1'b0, step};
    y_next    = {1'b0, y_q} + {1'b0, step};
    x_last    = (x_next >= {1'b0, img_w_q});
    y_last    = (y_next >= {1'b0, img_h_q});
    od_last   = (od_q == num_od_q - 8'd1);
    req_valid = (state_q == S_RUN) && (outst_q != OUT_MAX);
    fire      = req_valid && itrans_ready && wtrans_ready;
    // A result with nothing outstanding is flagged and otherwise ignored.
    result_ok = pe_result_valid && (outst_q != OUT_ZERO);

    if (fire && !result_ok)      outst_d = outst_q + OUT_ONE;
    else if (!fire && result_ok) outst_d = outst_q - OUT_ONE;
    if (pe_result_valid && (outst_q == OUT_ZERO)) err_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          img_h_d  = cfg_img_h;
          img_w_d  = cfg_img_w;
          num_od_d = cfg_num_od;
          size_d   = cfg_size_type;
          x_d      = '0;
          y_d      = '0;
          od_d     = '0;
          outst_d  = '0;
          err_d    = 1'b0;
`ifdef SCHED_PERF_EN
          perf_d   = '0;
`endif
          if (cfg_img_h == 9'd0 || cfg_img_w == 9'd0 || cfg_num_od == 8'd0) state_d = S_DONE;
          else                                                               state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (fire) begin
          if (!od_last) begin
            od_d = od_q + 8'd1;
          end else begin
            od_d = '0;
            if (!x_last) begin
              x_d = x_next[8:0];
            end else begin
              x_d = '0;
              if (!y_last) y_d = y_next[8:0];
              else         state_d = S_DRAIN;
            end
          end
        end
`ifdef SCHED_PERF_EN
        if (req_valid && !fire && (perf_q != 32'hFFFF_FFFF)) perf_d = perf_q + 32'd1;
`endif
      end
      S_DRAIN: begin
        if (outst_q == OUT_ZERO) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      od_q     <= '0;
      img_h_q  <= '0;
      img_w_q  <= '0;
      num_od_q <= '0;
      size_q   <= 1'b0;
      outst_q  <= '0;
      err_q    <= 1'b0;
`ifdef SCHED_PERF_EN
      perf_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      od_q     <= od_d;
      img_h_q  <= img_h_d;
      img_w_q  <= img_w_d;
      num_od_q <= num_od_d;
      size_q   <= size_d;
      outst_q  <= outst_d;
      err_q    <= err_d;
`ifdef SCHED_PERF_EN
      perf_q   <= perf_d;
`endif
    end
  end

  assign data_x_index     = x_q;
  assign data_y_index     = y_q;
  assign weight_od        = od_q;
  assign weight_size_type = size_q;
  assign busy             = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done             = (state_q == S_DONE);
  assign err_overflow     = err_q;
`ifdef SCHED_PERF_EN
  assign perf_stall_cycles = perf_q;
`endif

endmodule

// File: tb/tb_pe_tile_scheduler.sv
// Purpose: randomized and directed bench for pe_tile_scheduler against a loop-nest reference model.
// Latency: n/a (bench); each job is bounded by a cycle budget.
// Backpressure: readies and PE result timing are driven by the bench per test mode.
module tb_pe_tile_scheduler;

  typedef struct packed {
    logic [8:0] x;
    logic [8:0] y;
    logic [7:0] o;
  } req_t;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [8:0] cfg_img_h, cfg_img_w;
  logic [7:0] cfg_num_od;
  logic       cfg_size_type, itrans_ready, wtrans_ready;
  logic       req_valid;
  logic [8:0] data_x_index, data_y_index;
  logic [7:0] weight_od;
  logic       weight_size_type, pe_result_valid, busy, done, err_overflow;
`ifdef SCHED_PERF_EN
  logic [31:0] perf_stall_cycles;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pe_tile_scheduler #(.OUTSTANDING_W(6)) dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_img_h(cfg_img_h), .cfg_img_w(cfg_img_w), .cfg_num_od(cfg_num_od),
    .cfg_size_type(cfg_size_type), .itrans_ready(itrans_ready), .wtrans_ready(wtrans_ready),
    .req_valid(req_valid), .data_x_index(data_x_index), .data_y_index(data_y_index),
    .weight_od(weight_od), .weight_size_type(weight_size_type),
    .pe_result_valid(pe_result_valid), .busy(busy), .done(done), .err_overflow(err_overflow)
`ifdef SCHED_PERF_EN
    , .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic pulse_start(input int h, input int w, input int nod, input bit st);
    @(negedge clk);
    cfg_img_h     = 9'(h);
    cfg_img_w     = 9'(w);
    cfg_num_od    = 8'(nod);
    cfg_size_type = st;
    itrans_ready  = 1'b1;
    wtrans_ready  = 1'b1;
    pe_result_valid = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // mode 0: random readies/latency, 1: 5-cycle weight stall, 2: results withheld until all issued,
  // 3: readies high with fixed 3-cycle PE latency, 4: results withheld until outstanding saturates
  task automatic run_job(input int h, input int w, input int nod, input bit st, input int mode);
    req_t exp_q[$];
    int   due_q[$];
    req_t got, prev_req, r;
    bit   ir, wr, rv, fire, prev_pend, hold;
    int   total, nfire, ndone, done_k, outst, stalls, first_fire, last_fire, last_res, ws_left, step;
    step = st ? 4 : 6;
    for (int y = 0; y < h; y += step)
      for (int x = 0; x < w; x += step)
        for (int o = 0; o < nod; o++) begin
          r.x = 9'(x); r.y = 9'(y); r.o = 8'(o);
          exp_q.push_back(r);
        end
    total = exp_q.size();
    nfire = 0; ndone = 0; done_k = -1; outst = 0; stalls = 0;
    first_fire = -1; last_fire = -1; last_res = -1; ws_left = 5; prev_pend = 1'b0; prev_req = '0;
    pulse_start(h, w, nod, st);
    for (int k = 1; k <= 20000 && !(ndone > 0 && k > done_k + 2); k++) begin
      @(negedge clk);
      ir = 1'b1; wr = 1'b1;
      if (mode == 0) begin
        ir = ($urandom_range(0, 3) != 0);
        wr = ($urandom_range(0, 3) != 0);
      end else if (mode == 1 && nfire >= 3 && ws_left > 0) begin
        wr = 1'b0;
        ws_left--;
      end
      hold = (mode == 2 && nfire < total) || (mode == 4 && outst < 63 && nfire < total);
      rv = !hold && (due_q.size() > 0) && (due_q[0] <= k);
      if (rv) void'(due_q.pop_front());
      itrans_ready = ir;
      wtrans_ready = wr;
      pe_result_valid = rv;
      got = {data_x_index, data_y_index, weight_od};
      if (k == 1) begin
        check_eq("first_req_valid", 32'(req_valid), 32'd1);
        check_eq("first_busy", 32'(busy), 32'd1);
        check_eq("size_type_latched", 32'(weight_size_type), 32'(st));
      end
      if (done) begin
        ndone++;
        done_k = k;
        check_eq("busy_low_at_done", 32'(busy), 32'd0);
      end
      if (outst == 63) check_eq("max_outst_mask", 32'(req_valid), 32'd0);
      if (prev_pend && req_valid) check_eq("held_fields", 32'(got), 32'(prev_req));
      fire = req_valid && ir && wr;
      if (req_valid && !fire) stalls++;
      if (fire) begin
        check_eq("issue_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check_eq("issue_xyo", 32'(got), 32'(exp_q.pop_front()));
        nfire++;
        if (first_fire < 0) first_fire = k;
        last_fire = k;
        due_q.push_back(k + ((mode == 0) ? int'($urandom_range(1, 6)) : 3));
        outst++;
      end
      if (rv) begin
        outst--;
        if (outst == 0 && nfire == total) last_res = k;
      end
      prev_pend = req_valid && !fire;
      prev_req  = got;
    end
    check_eq("all_issued", 32'(nfire), 32'(total));
    check_eq("done_count", 32'(ndone), 32'd1);
    check_eq("err_overflow_clear", 32'(err_overflow), 32'd0);
`ifdef SCHED_PERF_EN
    check_eq("perf_stall", perf_stall_cycles, 32'(stalls));
`endif
    if (mode == 3) begin
      check_eq("first_fire_cycle", 32'(first_fire), 32'd1);
      check_eq("back_to_back", 32'(last_fire - first_fire + 1), 32'(total));
    end
    if (mode == 1) check_eq("stall_cycles", 32'(stalls), 32'd5);
    if (mode == 2) check_eq("done_after_last_result", 32'((done_k - last_res) inside {1, 2}), 32'd1);
    pe_result_valid = 1'b0;
  endtask

  initial begin
    int nd;
    reset = 1'b0; start = 1'b0; cfg_img_h = '0; cfg_img_w = '0; cfg_num_od = '0;
    cfg_size_type = 1'b0; itrans_ready = 1'b0; wtrans_ready = 1'b0; pe_result_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_outputs", 32'({req_valid, data_x_index, data_y_index, weight_od,
             weight_size_type, busy, done, err_overflow}), 32'd0);
    reset = 1'b1;

    run_job(8, 8, 2, 1'b1, 3);
    run_job(6, 10, 1, 1'b0, 3);
    run_job(12, 12, 2, 1'b1, 1);
    run_job(8, 8, 3, 1'b1, 2);

    // a stray result with nothing outstanding
    @(negedge clk) pe_result_valid = 1'b1;
    @(negedge clk) pe_result_valid = 1'b0;
    check_eq("err_overflow_set", 32'(err_overflow), 32'd1);

    run_job(4, 4, 70, 1'b1, 4);

    // zero channels: done without any request
    pulse_start(8, 8, 0, 1'b1);
    nd = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done) nd++;
      check_eq("degen_req_valid", 32'(req_valid), 32'd0);
    end
    check_eq("degen_done_count", 32'(nd), 32'd1);

    // reset in the middle of a job
    pulse_start(16, 16, 2, 1'b1);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("midrun_reset_outputs", 32'({req_valid, data_x_index, data_y_index, weight_od,
             weight_size_type, busy, done, err_overflow}), 32'd0);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("no_done_after_abort", 32'(done), 32'd0);
    end
    run_job(9, 13, 2, 1'b0, 3);

    for (int j = 0; j < 8; j++)
      run_job($urandom_range(1, 30), $urandom_range(1, 30), $urandom_range(1, 3),
              1'($urandom_range(0, 1)), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #10ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
